// File: rtl/unified_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the unified IF/MEM memory arbiter:
//   - arb_state_t : access sequencer states (IDLE -> ISSUE -> WAIT -> RESP)
//   - arb_owner_t : which requester owns the access in flight
//   - LAT_W       : width of the fixed-latency wait counter (MEM_LAT up to 15)
//   - STARVE_SAT  : saturation value of the IF starvation counter
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    localparam int LAT_W = 4;
    localparam logic [2:0] STARVE_SAT = 3'd7;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bundles the IF-stage port, the MEM-stage port and the single-port memory
// port of the arbiter.
//   slave  : arbiter side (takes requests and read data, drives acks/stalls
//            and the memory strobe)
//   master : environment side (IF stage, MEM stage and memory together)
// Parameters ADDR_W / DATA_W must match those of the arbiter instance.
// -----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // IF stage (read-only)
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_stall_o;
    // MEM stage (load/store)
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_stall_o;
    // memory
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    // status
    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_ack_o, if_rdata_o, if_stall_o,
        output d_ack_o, d_rdata_o, d_stall_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_ack_o, if_rdata_o, if_stall_o,
        input  d_ack_o, d_rdata_o, d_stall_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  busy_o
    );
endinterface

// File: rtl/unified_mem_arbiter_lat_timer.sv
// -----------------------------------------------------------------------------
// mem_lat_timer
// Load/decrement counter that times the fixed memory latency of one access.
// Ports:
//   clk_i      in  clock
//   rst_i      in  synchronous active-low reset, clears the count
//   load_i     in  load load_val_i (has priority over dec_i)
//   load_val_i in  value to load
//   dec_i      in  decrement by one, holds at zero
//   done_o     out count is zero
// -----------------------------------------------------------------------------
module mem_lat_timer
    import arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);
    logic [LAT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (dec_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done_o = (r_cnt == '0);
endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port memory between the IF stage (reads only) and the MEM
// stage (loads/stores). Every access runs IDLE -> ISSUE -> WAIT (MEM_LAT
// cycles) -> RESP, so a request seen in IDLE at cycle t is acked at
// t+2+MEM_LAT. The data side wins ties unless IF has lost STARVE_MAX
// consecutive contested arbitrations.
// Ports:
//   clk_i            in   clock
//   rst_i            in   synchronous active-low reset
//   bus (slave)      IF request/ack/rdata/stall, MEM-stage request/ack/
//                    rdata/stall, memory strobe/we/addr/wdata/rdata, busy
//   if_stall_cnt_o   out  cycles with if_stall_o=1 (ARB_PERF_CNT_EN only)
//   d_stall_cnt_o    out  cycles with d_stall_o=1  (ARB_PERF_CNT_EN only)
// Build option: define ARB_PERF_CNT_EN to add the saturating stall counters.
// -----------------------------------------------------------------------------
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]          if_stall_cnt_o,
    output logic [31:0]          d_stall_cnt_o,
`endif
    unified_mem_arbiter_if.slave bus
);
    // ISSUE loads MEM_LAT-1 so WAIT lasts exactly MEM_LAT cycles.
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 1);
    localparam logic [2:0]       STARVE_LIM = 3'(STARVE_MAX);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic [2:0]        r_starve;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_grant_if;
    logic              w_grant_d;
    logic              w_lat_load;
    logic              w_lat_dec;
    logic              w_lat_done;
    logic              w_capture;
    logic              w_if_ack;
    logic              w_d_ack;
    logic              w_if_stall;
    logic              w_d_stall;

    assign w_lat_load = (r_state == ISSUE);
    assign w_lat_dec  = (r_state == WAIT);
    assign w_capture  = (r_state == WAIT) && w_lat_done;

    mem_lat_timer u_lat_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_lat_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (w_lat_dec),
        .done_o     (w_lat_done)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            IDLE: begin
                // IF wins when alone or when it has been starved long enough.
                if (bus.if_req_i && (!bus.d_req_i || (r_starve >= STARVE_LIM))) begin
                    w_grant_if = 1'b1;
                end else if (bus.d_req_i) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_if || w_grant_d) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_lat_done) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_owner     <= OWN_NONE;
            r_starve    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            if (w_grant_if) begin
                r_owner    <= OWN_IF;
                r_mem_we   <= 1'b0;
                r_mem_addr <= bus.if_addr_i;
                r_starve   <= '0;
            end
            if (w_grant_d) begin
                r_owner     <= OWN_D;
                r_mem_we    <= bus.d_we_i;
                r_mem_addr  <= bus.d_addr_i;
                r_mem_wdata <= bus.d_wdata_i;
                // Only a contested loss counts as starvation.
                if (bus.if_req_i && (r_starve != STARVE_SAT)) begin
                    r_starve <= r_starve + 3'd1;
                end
            end
            if (w_capture) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= bus.mem_rdata_i;
                end else if ((r_owner == OWN_D) && !r_mem_we) begin
                    r_d_rdata <= bus.mem_rdata_i;
                end
            end
            if (r_state == RESP) begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign w_if_ack   = (r_state == RESP) && (r_owner == OWN_IF);
    assign w_d_ack    = (r_state == RESP) && (r_owner == OWN_D);
    assign w_if_stall = bus.if_req_i && !w_if_ack;
    assign w_d_stall  = bus.d_req_i && !w_d_ack;

    assign bus.if_ack_o    = w_if_ack;
    assign bus.d_ack_o     = w_d_ack;
    assign bus.if_stall_o  = w_if_stall;
    assign bus.d_stall_o   = w_d_stall;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.d_rdata_o   = r_d_rdata;
    assign bus.mem_en_o    = (r_state == ISSUE);
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;
    assign bus.busy_o      = (r_state != IDLE);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_if_stall_cnt;
    logic [31:0] r_d_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_if_stall_cnt <= '0;
            r_d_stall_cnt  <= '0;
        end else begin
            if (w_if_stall && (r_if_stall_cnt != 32'hFFFF_FFFF)) begin
                r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
            end
            if (w_d_stall && (r_d_stall_cnt != 32'hFFFF_FFFF)) begin
                r_d_stall_cnt <= r_d_stall_cnt + 32'd1;
            end
        end
    end

    assign if_stall_cnt_o = r_if_stall_cnt;
    assign d_stall_cnt_o  = r_d_stall_cnt;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Directed scenarios followed by a randomized run against a transaction-level
// model of the arbiter (grant rule, fixed access timing, memory contents).
// A behavioural memory returns valid read data only on the exact sampling
// cycle and random junk on every other cycle.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt;
    logic [31:0] d_stall_cnt;
`endif

    unified_mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
`ifdef ARB_PERF_CNT_EN
        .if_stall_cnt_o (if_stall_cnt),
        .d_stall_cnt_o  (d_stall_cnt),
`endif
        .bus            (bus)
    );

    // Behavioural memory: 256 words, word index = addr[9:2].
    logic [31:0] mem_model [0:255];
    int          pend_cyc;
    logic [7:0]  pend_idx;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 32'h1000_0000 + 32'(i) * 32'h0001_0101;
            mem_model[8'h10] <= 32'hDEAD_BEEF;
            pend_cyc <= -1;
        end else if (bus.mem_en_o) begin
            pend_cyc <= cyc + MEM_LAT;
            pend_idx <= bus.mem_addr_o[9:2];
            if (bus.mem_we_o) mem_model[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
        end
        if (cyc == pend_cyc) bus.mem_rdata_i <= mem_model[pend_idx];
        else                 bus.mem_rdata_i <= $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.if_req_i  = 1'b0;
        bus.if_addr_i = '0;
        bus.d_req_i   = 1'b0;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = '0;
        bus.d_wdata_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_reqs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // reference model state for the randomized run
    int          m_free, m_grant, m_issue, m_ack, m_own, m_starve;
    logic [31:0] exp_d, rd_d0;
    logic        e_if_ack, e_d_ack;

    initial begin
        clear_reqs();
        do_reset();

        // ---------------- reset state ----------------
        chk("rst_if_ack", bus.if_ack_o, 0);
        chk("rst_d_ack", bus.d_ack_o, 0);
        chk("rst_if_rdata", bus.if_rdata_o, 0);
        chk("rst_d_rdata", bus.d_rdata_o, 0);
        chk("rst_mem_en", bus.mem_en_o, 0);
        chk("rst_mem_we", bus.mem_we_o, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_if_stall", bus.if_stall_o, 0);
        chk("rst_d_stall", bus.d_stall_o, 0);
`ifdef ARB_PERF_CNT_EN
        chk("rst_if_cnt", if_stall_cnt, 0);
        chk("rst_d_cnt", d_stall_cnt, 0);
`endif

        // ---------------- single IF read of 0x40 ----------------
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
        #1;
        chk("s1_stall_c0", bus.if_stall_o, 1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("s1_en_c%0d", c), bus.mem_en_o, c == 1);
            chk($sformatf("s1_ack_c%0d", c), bus.if_ack_o, c == 4);
            chk($sformatf("s1_busy_c%0d", c), bus.busy_o, c <= 4);
            chk($sformatf("s1_stall_c%0d", c), bus.if_stall_o, c < 4);
            if (c == 1) begin
                chk("s1_addr", bus.mem_addr_o, 32'h40);
                chk("s1_we", bus.mem_we_o, 0);
            end
            if (c == 4) begin
                chk("s1_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
                bus.if_req_i = 1'b0;
            end
        end

        // ---------------- IF and data read contend ----------------
        do_reset();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h80;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h100;
        #1;
        chk("s2_if_stall_c0", bus.if_stall_o, 1);
        chk("s2_d_stall_c0", bus.d_stall_o, 1);
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("s2_en_c%0d", c), bus.mem_en_o, (c == 1) || (c == 6));
            chk($sformatf("s2_d_ack_c%0d", c), bus.d_ack_o, c == 4);
            chk($sformatf("s2_if_ack_c%0d", c), bus.if_ack_o, c == 9);
            chk($sformatf("s2_if_stall_c%0d", c), bus.if_stall_o, c <= 8);
            chk($sformatf("s2_d_stall_c%0d", c), bus.d_stall_o, c <= 3);
            chk($sformatf("s2_busy_c%0d", c), bus.busy_o, (c <= 4) || ((c >= 6) && (c <= 9)));
            if (c == 1) chk("s2_addr_d", bus.mem_addr_o, 32'h100);
            if (c == 4) begin
                chk("s2_d_rdata", bus.d_rdata_o, mem_model[8'h40]);
                bus.d_req_i = 1'b0;
            end
            if (c == 6) begin
                chk("s2_addr_if", bus.mem_addr_o, 32'h80);
                chk("s2_we_if", bus.mem_we_o, 0);
            end
            if (c == 9) begin
                chk("s2_if_rdata", bus.if_rdata_o, mem_model[8'h20]);
                bus.if_req_i = 1'b0;
            end
        end
`ifdef ARB_PERF_CNT_EN
        chk("s2_if_cnt", if_stall_cnt, 9);
        chk("s2_d_cnt", d_stall_cnt, 4);
`endif

        // ---------------- IF starvation limit ----------------
        do_reset();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h44;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h104;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("s3_en_c%0d", c), bus.mem_en_o, (c == 1) || (c == 6) || (c == 11) || (c == 16));
            chk($sformatf("s3_d_ack_c%0d", c), bus.d_ack_o, (c == 4) || (c == 9));
            chk($sformatf("s3_if_ack_c%0d", c), bus.if_ack_o, c == 14);
            if (c == 1)  chk("s3_addr_1", bus.mem_addr_o, 32'h104);
            if (c == 6)  chk("s3_addr_2", bus.mem_addr_o, 32'h108);
            if (c == 11) chk("s3_addr_3", bus.mem_addr_o, 32'h44);
            if (c == 16) chk("s3_addr_4", bus.mem_addr_o, 32'h10C);
            if (c == 4)  bus.d_addr_i = 32'h108;
            if (c == 9)  bus.d_addr_i = 32'h10C;
            if (c == 14) bus.if_addr_i = 32'h4C;
        end

        // ---------------- write leaves d_rdata alone ----------------
        do_reset();
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h100;
        rd_d0 = 32'h0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 4) begin
                chk("s4_rd_ack", bus.d_ack_o, 1);
                rd_d0 = mem_model[8'h40];
                chk("s4_rd_data", bus.d_rdata_o, rd_d0);
                bus.d_we_i = 1'b1; bus.d_addr_i = 32'h200; bus.d_wdata_i = 32'h1234;
            end
            if (c == 6) begin
                chk("s4_wr_en", bus.mem_en_o, 1);
                chk("s4_wr_we", bus.mem_we_o, 1);
                chk("s4_wr_addr", bus.mem_addr_o, 32'h200);
                chk("s4_wr_wdata", bus.mem_wdata_o, 32'h1234);
            end
            if (c == 9) begin
                chk("s4_wr_ack", bus.d_ack_o, 1);
                chk("s4_wr_rdata_held", bus.d_rdata_o, rd_d0);
                bus.d_we_i = 1'b0; bus.d_wdata_i = 32'h0;
            end
            if (c == 14) begin
                chk("s4_rb_ack", bus.d_ack_o, 1);
                chk("s4_rb_data", bus.d_rdata_o, 32'h1234);
                bus.d_req_i = 1'b0;
            end
        end

        // ---------------- reset during WAIT ----------------
        tick();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h48;
        tick();
        chk("s5_en", bus.mem_en_o, 1);
        tick();
        rst = 1'b0;
        clear_reqs();
        tick();
        chk("s5_busy", bus.busy_o, 0);
        chk("s5_mem_addr", bus.mem_addr_o, 0);
        chk("s5_mem_we", bus.mem_we_o, 0);
        chk("s5_mem_wdata", bus.mem_wdata_o, 0);
        chk("s5_d_rdata", bus.d_rdata_o, 0);
        chk("s5_if_rdata", bus.if_rdata_o, 0);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("s5_no_ack_%0d", c), bus.if_ack_o, 0);
            chk($sformatf("s5_idle_%0d", c), bus.busy_o, 0);
        end
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("s5_fresh_en_c%0d", c), bus.mem_en_o, c == 1);
            chk($sformatf("s5_fresh_ack_c%0d", c), bus.if_ack_o, c == 4);
        end
        chk("s5_fresh_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
        bus.if_req_i = 1'b0;

        // ---------------- randomized run vs model ----------------
        do_reset();
        m_free = cyc; m_grant = -100; m_issue = -100; m_ack = -100;
        m_own = 0; m_starve = 0; exp_d = 32'h0;
        for (int n = 0; n < 600; n++) begin
            tick();
            e_if_ack = (m_own == 1) && (cyc == m_ack);
            e_d_ack  = (m_own == 2) && (cyc == m_ack);
            chk("r_if_ack", bus.if_ack_o, e_if_ack);
            chk("r_d_ack", bus.d_ack_o, e_d_ack);
            chk("r_en", bus.mem_en_o, cyc == m_issue);
            chk("r_busy", bus.busy_o, (cyc > m_grant) && (cyc <= m_ack));
            chk("r_if_stall", bus.if_stall_o, bus.if_req_i & ~e_if_ack);
            chk("r_d_stall", bus.d_stall_o, bus.d_req_i & ~e_d_ack);
            if (cyc == m_issue) begin
                chk("r_addr", bus.mem_addr_o, (m_own == 1) ? bus.if_addr_i : bus.d_addr_i);
                chk("r_we", bus.mem_we_o, (m_own == 2) && bus.d_we_i);
                if ((m_own == 2) && bus.d_we_i) chk("r_wdata", bus.mem_wdata_o, bus.d_wdata_i);
            end
            if (e_if_ack) begin
                chk("r_if_rdata", bus.if_rdata_o, mem_model[bus.if_addr_i[9:2]]);
                bus.if_req_i = 1'b0;
            end
            if (e_d_ack) begin
                if (!bus.d_we_i) exp_d = mem_model[bus.d_addr_i[9:2]];
                chk("r_d_rdata", bus.d_rdata_o, exp_d);
                bus.d_req_i = 1'b0;
            end
            if (!bus.if_req_i && ($urandom_range(3) == 0)) begin
                bus.if_req_i  = 1'b1;
                bus.if_addr_i = 32'($urandom_range(255)) << 2;
            end
            if (!bus.d_req_i && ($urandom_range(2) == 0)) begin
                bus.d_req_i   = 1'b1;
                bus.d_we_i    = ($urandom_range(2) == 0);
                bus.d_addr_i  = 32'($urandom_range(255)) << 2;
                bus.d_wdata_i = $urandom;
            end
            if (cyc >= m_free) begin
                if (bus.if_req_i && (!bus.d_req_i || (m_starve >= STARVE_MAX))) begin
                    m_own = 1; m_starve = 0;
                end else if (bus.d_req_i) begin
                    m_own = 2;
                    if (bus.if_req_i && (m_starve < 7)) m_starve++;
                end else begin
                    m_own = 0;
                end
                if (m_own != 0) begin
                    m_grant = cyc;
                    m_issue = cyc + 1;
                    m_ack   = cyc + 2 + MEM_LAT;
                    m_free  = cyc + 3 + MEM_LAT;
                end else begin
                    m_free = cyc + 1;
                end
            end
        end
        clear_reqs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
